// File: rtl/eit_pkg.sv
// Shared constants, drain-state encoding and output word record for the EIT sample averager.
package eit_pkg;

  localparam int NUM_CH    = 8;
  localparam int AVG_LOG2  = 2;
  localparam int NUM_STEPS = 16;
  localparam int STEP_W    = 4;
  localparam int CH_W      = 3;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = DATA_W + AVG_LOG2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   channel;
    logic [STEP_W-1:0] step;
    logic              sof;
    logic              eof;
  } out_word_t;

  function automatic logic [CH_W-1:0] lowest_hit(input logic [NUM_CH-1:0] mask);
    lowest_hit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_hit = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/eit_acc_bank.sv
// One accumulator bank: per-channel signed sums, hit mask, full flag and an indexed read port.
module eit_acc_bank
  import eit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              acc_en,
  input  logic [CH_W-1:0]   acc_ch,
  input  logic [DATA_W-1:0] acc_data,
  input  logic              set_full,
  input  logic              hit_clr,
  input  logic [CH_W-1:0]   hit_clr_ch,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ACC_W-1:0]  rd_acc,
  output logic [NUM_CH-1:0] hit,
  output logic              full
);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [NUM_CH-1:0] hit_q;
  logic              full_q;
  logic [ACC_W-1:0]  acc_ext;

  assign acc_ext = {{AVG_LOG2{acc_data[DATA_W-1]}}, acc_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '{default: '0};
      hit_q  <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      acc_q  <= '{default: '0};
      hit_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (acc_en) begin
        acc_q[acc_ch] <= acc_q[acc_ch] + acc_ext;
        hit_q[acc_ch] <= 1'b1;
      end
      if (hit_clr) hit_q[hit_clr_ch] <= 1'b0;
      if (set_full) full_q <= 1'b1;
    end
  end

  assign rd_acc = acc_q[rd_ch];
  assign hit    = hit_q;
  assign full   = full_q;

endmodule

// File: rtl/eit_sample_averager.sv
// Ping-pong coherent averager: fills one bank while the drain FSM streams the other as tagged words.
module eit_sample_averager
  import eit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              set_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic [STEP_W-1:0] out_step,
  output logic              out_sof,
  output logic              out_eof,
  output logic              overrun_err,
  output logic              busy
);

  logic [1:0]          full;
  logic [NUM_CH-1:0]   hit [2];
  logic [ACC_W-1:0]    rd_acc [2];

  logic                fill_q, drop_q, overrun_q;
  logic                drain_q, drain_d;
  logic [AVG_LOG2-1:0] set_cnt_q;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          state_q, state_d;
  logic                first_q, first_d;
  out_word_t           word_q, word_d;

  logic                in_range, cap, set_ok, close_set, done, send_fire, other_busy;
  logic [NUM_CH-1:0]   scan_hit, rest_hit;
  logic [CH_W-1:0]     scan_ch;

  assign in_range   = int'(in_channel) < NUM_CH;
  assign cap        = in_valid & in_range & ~drop_q & ~clear;
  assign set_ok     = set_done & ~drop_q & ~clear;
  assign close_set  = set_ok & (set_cnt_q == '1);
  assign done       = state_q == StDone;
  assign send_fire  = (state_q == StSend) & out_ready;
  // A bank being cleared this cycle is free for the next fill.
  assign other_busy = full[~fill_q] & ~(done & (drain_q == ~fill_q));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    eit_acc_bank u_bank (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (clear | (done & (drain_q == 1'(b)))),
      .acc_en     (cap & (fill_q == 1'(b))),
      .acc_ch     (in_channel),
      .acc_data   (in_data),
      .set_full   (close_set & (fill_q == 1'(b))),
      .hit_clr    (send_fire & (drain_q == 1'(b))),
      .hit_clr_ch (word_q.channel),
      .rd_ch      (scan_ch),
      .rd_acc     (rd_acc[b]),
      .hit        (hit[b]),
      .full       (full[b])
    );
  end

  assign scan_hit = hit[drain_q];
  assign scan_ch  = lowest_hit(scan_hit);
  assign rest_hit = scan_hit & ~(NUM_CH'(1) << scan_ch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q    <= 1'b0;
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
      set_cnt_q <= '0;
    end else if (clear) begin
      fill_q    <= 1'b0;
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
      set_cnt_q <= '0;
    end else begin
      if (set_ok) set_cnt_q <= set_cnt_q + 1'b1;
      if (close_set) begin
        if (other_busy) begin
          drop_q    <= 1'b1;
          overrun_q <= 1'b1;
        end else begin
          fill_q <= ~fill_q;
        end
      end
      if (drop_q && done) begin
        drop_q <= 1'b0;
        fill_q <= drain_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    first_d = first_q;
    step_d  = step_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (full[drain_q]) begin
          state_d = StScan;
          first_d = 1'b1;
        end
      end
      StScan: begin
        if (scan_hit == '0) begin
          state_d = StDone;
        end else begin
          word_d.data    = DATA_W'($signed(rd_acc[drain_q]) >>> AVG_LOG2);
          word_d.channel = scan_ch;
          word_d.step    = step_q;
          word_d.sof     = first_q & (step_q == '0);
          word_d.eof     = (rest_hit == '0) & (step_q == STEP_W'(NUM_STEPS - 1));
          first_d        = 1'b0;
          state_d        = StSend;
        end
      end
      StSend: begin
        if (out_ready) state_d = StScan;
      end
      default: begin
        step_d  = (step_q == STEP_W'(NUM_STEPS - 1)) ? '0 : step_q + 1'b1;
        drain_d = ~drain_q;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      first_q <= 1'b0;
      step_q  <= '0;
      drain_q <= 1'b0;
    end else if (clear) begin
      state_q <= StIdle;
      word_q  <= '0;
      first_q <= 1'b0;
      step_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      first_q <= first_d;
      step_q  <= step_d;
      drain_q <= drain_d;
    end
  end

  assign out_valid   = state_q == StSend;
  assign out_data    = word_q.data;
  assign out_channel = word_q.channel;
  assign out_step    = word_q.step;
  assign out_sof     = word_q.sof;
  assign out_eof     = word_q.eof;
  assign overrun_err = overrun_q;
  assign busy        = state_q != StIdle;

endmodule

// File: tb/tb_eit_sample_averager.sv
// Scoreboard bench: expected averaged words are queued at stimulus time and popped on each handshake.
module tb_eit_sample_averager;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, set_done, out_ready;
  logic [2:0]  in_channel;
  logic [15:0] in_data;
  logic        out_valid, out_sof, out_eof, overrun_err, busy;
  logic [15:0] out_data;
  logic [2:0]  out_channel;
  logic [3:0]  out_step;
  logic [24:0] out_word;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic [3:0]  step;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          sd_cyc = 0;
  int          m_step = 0;
  int          blk_val [4][8];
  bit          toggle_en = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_clear = 1'b0;
  logic [24:0] prev_word = '0;

  eit_sample_averager dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_channel  (in_channel),
    .in_data     (in_data),
    .set_done    (set_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_step    (out_step),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (toggle_en) #1 out_ready = ~out_ready;

  assign out_word = {out_data, out_channel, out_step, out_sof, out_eof};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor plus hold-stable check while the consumer stalls.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_empty", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", 32'(out_word), 32'(mon_e));
        end
      end
      if (prev_valid && !prev_ready && !prev_clear)
        check("hold", 32'({out_valid, out_word}), 32'({1'b1, prev_word}));
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
    prev_clear <= clear;
    prev_word  <= out_word;
  end

  task automatic beat(input logic v, input logic [2:0] ch, input logic [15:0] d, input logic sd);
    in_valid   = v;
    in_channel = ch;
    in_data    = d;
    set_done   = sd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_done = 1'b0;
  endtask

  task automatic fill_rand();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) blk_val[s][k] = int'($urandom_range(65535)) - 32768;
  endtask

  // Last sample of each set carries set_done, so it must land in the closing set.
  task automatic run_block(input logic [7:0] mask, input bit dropped);
    int   sum [8];
    int   last;
    bit   first;
    exp_t e;
    last = 0;
    for (int k = 0; k < 8; k++) begin
      sum[k] = 0;
      if (mask[k]) last = k;
    end
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        if (mask[k]) begin
          sum[k] += blk_val[s][k];
          if (k == last) sd_cyc = cyc;
          beat(1'b1, 3'(k), 16'(blk_val[s][k]), k == last);
        end
      end
    end
    if (!dropped) begin
      first = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (mask[k]) begin
          e.data = 16'(sum[k] >>> 2);
          e.ch   = 3'(k);
          e.step = 4'(m_step);
          e.sof  = first && (m_step == 0);
          e.eof  = (k == last) && (m_step == 15);
          exp_q.push_back(e);
          first  = 1'b0;
        end
      end
      m_step = (m_step + 1) % 16;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
    check({"idle_", tag}, 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_channel = '0; in_data = '0;
    set_done = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({out_valid, busy, overrun_err, out_word}), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // All channels, constant per-channel value; checks latency and sof.
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) blk_val[s][k] = 100 * k + 1;
    run_block(8'hff, 1'b0);
    wait_valid();
    check("latency", cyc - sd_cyc, 3);
    wait_drain("t1");

    // Floor rounding of positive and negative sums.
    blk_val[0][0] = 3;  blk_val[1][0] = 4;  blk_val[2][0] = 4;  blk_val[3][0] = -8;
    blk_val[0][1] = -1; blk_val[1][1] = -1; blk_val[2][1] = -1; blk_val[3][1] = -2;
    run_block(8'h03, 1'b0);
    wait_drain("t2");

    // Sparse mask with a toggling consumer.
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) blk_val[s][k] = 37 * s - 50 * k + 9;
    toggle_en = 1'b1;
    run_block(8'h24, 1'b0);
    wait_drain("t3");
    toggle_en = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    // Stalled consumer: two blocks buffered, third dropped.
    check("ovr_before", 32'(overrun_err), 0);
    out_ready = 1'b0;
    fill_rand(); run_block(8'hff, 1'b0);
    fill_rand(); run_block(8'hff, 1'b0);
    fill_rand(); run_block(8'hff, 1'b1);
    @(negedge clk);
    check("ovr_set", 32'(overrun_err), 1);
    check("stall_valid", 32'(out_valid), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("t4a");
    fill_rand(); run_block(8'h81, 1'b0);
    wait_drain("t4b");

    // Back-to-back blocks across the step wrap.
    for (int b = 0; b < 16; b++) begin
      fill_rand();
      run_block(8'hff, 1'b0);
    end
    wait_drain("t5");

    // Clear mid-SEND with a sample and set_done in the same cycle.
    out_ready = 1'b0;
    fill_rand(); run_block(8'hff, 1'b1);
    wait_valid();
    check("t6_send", 32'(out_valid), 1);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_channel = 3'd3; in_data = 16'h1234; set_done = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; set_done = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(out_valid), 0);
    check("clr_step", 32'(out_step), 0);
    check("clr_ovr", 32'(overrun_err), 0);
    check("clr_busy", 32'(busy), 0);
    exp_q.delete();
    m_step = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) blk_val[s][k] = 7 * k - 20 + s;
    run_block(8'hff, 1'b0);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
